// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the CPU execute stage and a word-wide synchronous data RAM.
//   One request is handled at a time: loads read the addressed word and
//   extract a byte/halfword (sign- or zero-extended); SW writes directly;
//   SB/SH read the word, merge the new lane and write it back.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   op, addr, wdata   request fields, latched at acceptance
//   rdata             last completed load result
//   done, addr_err    completion pulse; addr_err flags a misaligned request
//   busy              an access is in flight
//   ram_*             word index, read/write enables and data for the RAM
module load_store_unit #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int unsigned DEPTH_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         op,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               done,
  output logic               addr_err,
  output logic               busy,
  output logic [DEPTH_W-1:0] ram_addr,
  output logic               ram_rena,
  output logic               ram_wena,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_p0;
  logic [31:0] addr_p0, wdata_p0, off_p0;
  logic [31:0] merge_p1;
  logic        accept, bad_req, is_load_p0, err_pend;
  logic        unused_off;

  function automatic logic misaligned(input logic [2:0] o, input logic [1:0] k);
    logic m;
    m = 1'b0;
    case (o)
      OP_LW, OP_SW:         m = (k != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = k[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] k,
                                          input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{k, 3'b000} +: 8];
    h = k[1] ? w[31:16] : w[15:0];
    case (o)
      OP_LB:   r = 32'(b);
      OP_LBU:  r = {24'h0, b};
      OP_LH:   r = 32'(h);
      OP_LHU:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] k,
                                        input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (o == OP_SB)
      r[{k, 3'b000} +: 8] = d[7:0];
    else if (k[1])
      r[31:16] = d[15:0];
    else
      r[15:0] = d[15:0];
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = req_valid & req_ready;
  assign bad_req    = misaligned(op, addr[1:0]);
  assign is_load_p0 = (op_p0 <= OP_LHU);

  // Addresses below the data segment are used as plain offsets; the
  // word index wraps on the RAM depth.
  assign off_p0     = (addr_p0 >= DATA_BASE) ? (addr_p0 - DATA_BASE) : addr_p0;
  assign ram_addr   = off_p0[DEPTH_W+1:2];
  assign unused_off = ^{off_p0[31:DEPTH_W+2], off_p0[1:0]};

  assign ram_rena   = (state == RD);
  assign ram_wena   = (state == WR) & ~rst;
  assign ram_wdata  = (op_p0 == OP_SW) ? wdata_p0 : merge_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !bad_req) state_nxt = (op == OP_SW) ? WR : RD;
      RD:   state_nxt = CAP;
      CAP:  state_nxt = is_load_p0 ? IDLE : WR;
      WR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: request capture and completion reporting.
  // A misaligned request leaves the unit idle but reports one edge later
  // through err_pend, matching the single-cycle store latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0    <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      addr_err <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      err_pend <= accept & bad_req;
      if (err_pend) begin
        done     <= 1'b1;
        addr_err <= 1'b1;
      end
      if (accept) begin
        op_p0    <= op;
        addr_p0  <= addr;
        wdata_p0 <= wdata;
      end
      if (state == CAP && is_load_p0) begin
        rdata <= extract(op_p0, addr_p0[1:0], ram_rdata);
        done  <= 1'b1;
      end
      if (state == WR) done <= 1'b1;
    end
  end

  // Stage p1: read-modify-write merge for sub-word stores.
  always_ff @(posedge clk) begin
    if (state == CAP) merge_p1 <= merge(op_p0, addr_p0[1:0], ram_rdata, wdata_p0);
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done, addr_err, busy;
  logic [10:0] ram_addr;
  logic        ram_rena, ram_wena;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  load_store_unit #(.DATA_BASE(BASE), .DEPTH_W(11)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .addr_err(addr_err), .busy(busy), .ram_addr(ram_addr), .ram_rena(ram_rena),
    .ram_wena(ram_wena), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with a preload port for the bench.
  logic [31:0] ram [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    if (ram_wena) ram[ram_addr] <= ram_wdata;
    if (ram_rena) ram_rdata <= ram[ram_addr];
  end

  // Expected behaviour per cycle (cycle c = window after the c-th posedge).
  bit          e_done [MAXC];
  bit          e_err  [MAXC];
  bit          e_rena [MAXC];
  bit          e_wena [MAXC];
  bit          e_rdset[MAXC];
  logic [31:0] e_addr [MAXC];
  logic [31:0] e_wdat [MAXC];
  logic [31:0] e_rdval[MAXC];
  logic [31:0] shadow [0:2047];
  int          idle_from = 0;
  logic [31:0] mrdata = 32'h0;
  int          last_idx = 0;
  logic [31:0] last_old = 32'h0;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_req(input int a, input logic [2:0] o, input logic [31:0] ad,
                           input logic [31:0] wd);
    logic [31:0] off, w, v, mask;
    int idx, sh;
    bit mis;
    off  = (ad >= BASE) ? ad - BASE : ad;
    idx  = int'((off / 4) % 2048);
    sh   = 8 * int'(ad % 4);
    mis  = (o == 3'd0 || o == 3'd5) ? (ad % 4 != 0) :
           (o == 3'd3 || o == 3'd4 || o == 3'd7) ? (ad % 2 != 0) : 1'b0;
    w    = shadow[idx];
    v    = 32'h0;
    if (mis) begin
      e_done[a+1] = 1; e_err[a+1] = 1; idle_from = a;
    end else if (o == 3'd5) begin
      e_wena[a] = 1; e_addr[a] = 32'(idx); e_wdat[a] = wd;
      shadow[idx] = wd; e_done[a+1] = 1; idle_from = a + 1;
    end else if (o <= 3'd4) begin
      case (o)
        3'd0:       v = w;
        3'd1, 3'd2: v = (w >> sh) & 32'hFF;
        default:    v = (w >> sh) & 32'hFFFF;
      endcase
      if (o == 3'd1 && v >= 32'd128)   v = v | 32'hFFFF_FF00;
      if (o == 3'd3 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      e_rena[a] = 1; e_addr[a] = 32'(idx);
      e_done[a+2] = 1; e_rdset[a+2] = 1; e_rdval[a+2] = v; idle_from = a + 2;
    end else begin
      mask = (o == 3'd6) ? (32'hFF << sh) : (32'hFFFF << sh);
      v = (w & ~mask) | ((wd << sh) & mask);
      last_idx = idx; last_old = w; shadow[idx] = v;
      e_rena[a] = 1; e_addr[a] = 32'(idx);
      e_wena[a+2] = 1; e_addr[a+2] = 32'(idx); e_wdat[a+2] = v;
      e_done[a+3] = 1; idle_from = a + 3;
    end
  endtask

  task automatic model_abort(input int w);
    for (int c = w; c < w + 6; c++) begin
      e_done[c] = 0; e_err[c] = 0; e_rena[c] = 0; e_wena[c] = 0; e_rdset[c] = 0;
    end
    e_rdset[w+1] = 1; e_rdval[w+1] = 32'h0;
    idle_from = w + 1;
    shadow[last_idx] = last_old;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (chk_en && cyc < MAXC - 8) begin
        if (e_rdset[cyc]) mrdata = e_rdval[cyc];
        chk("req_ready", 32'(req_ready), 32'(cyc >= idle_from));
        chk("busy",      32'(busy),      32'(cyc < idle_from));
        chk("done",      32'(done),      32'(e_done[cyc]));
        chk("addr_err",  32'(addr_err),  32'(e_err[cyc]));
        chk("ram_rena",  32'(ram_rena),  32'(e_rena[cyc]));
        chk("ram_wena",  32'(ram_wena),  32'(e_wena[cyc]));
        chk("rdata",     rdata,          mrdata);
        if (e_rena[cyc] || e_wena[cyc]) chk("ram_addr", 32'(ram_addr), e_addr[cyc]);
        if (e_wena[cyc]) chk("ram_wdata", ram_wdata, e_wdat[cyc]);
        if (done === 1'b1) done_seen++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       input bit hold);
    int n;
    n = 0;
    req_valid = 1'b1; op = o; addr = ad; wdata = wd;
    while (cyc < idle_from && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cyc < idle_from) begin
      chk("accept_wait", 32'(cyc), 32'(idle_from));
    end else begin
      model_req(cyc + 1, o, ad, wd);
      @(negedge clk);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 11'(idx); pre_val = val;
    shadow[idx] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    for (int i = 0; i < 2048; i++) shadow[i] = 32'h0;
    preload(0, 32'h8070_F0A5);
    preload(1, 32'h1122_3344);
    step(2);
    rst = 1'b0;
    idle_from = 0; mrdata = 32'h0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_rdata", rdata,          32'h0);
    chk_en = 1'b1;

    // Word store then load.
    issue(3'd5, 32'h1001_0008, 32'd123456, 0);
    chk("sw_wena",  32'(ram_wena), 32'd1);
    chk("sw_addr",  32'(ram_addr), 32'd2);
    chk("sw_wdata", ram_wdata,     32'd123456);
    step(1);
    chk("sw_done",  32'(done),     32'd1);
    issue(3'd0, 32'h1001_0008, 32'h0, 0);
    step(2);
    chk("lw_rdata", rdata,          32'd123456);
    chk("lw_err",   32'(addr_err),  32'd0);

    // Sub-word loads from word 0.
    issue(3'd1, 32'h0, 32'h0, 0); step(2); chk("lb_rdata",  rdata, 32'hFFFF_FFA5);
    issue(3'd2, 32'h3, 32'h0, 0); step(2); chk("lbu_rdata", rdata, 32'h0000_0080);
    issue(3'd3, 32'h2, 32'h0, 0); step(2); chk("lh_rdata",  rdata, 32'hFFFF_8070);
    issue(3'd4, 32'h0, 32'h0, 0); step(2); chk("lhu_rdata", rdata, 32'h0000_F0A5);

    // Read-modify-write stores on word 1.
    issue(3'd6, 32'h5, 32'hFF, 0);
    step(2);
    chk("sb_not_done_yet", 32'(done), 32'd0);
    step(1);
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_word", ram[1],    32'h1122_FF44);
    issue(3'd7, 32'h6, 32'hABCD, 0);
    step(3);
    chk("sh_word", ram[1], 32'hABCD_FF44);

    // Misaligned requests.
    issue(3'd0, 32'h2, 32'h0, 0);
    step(1);
    chk("mis_lw_done", 32'(done),     32'd1);
    chk("mis_lw_err",  32'(addr_err), 32'd1);
    issue(3'd3, 32'h1, 32'h0, 0);
    issue(3'd7, 32'h3, 32'h1, 0);
    step(3);
    chk("mis_rdata", rdata,  32'h0000_F0A5);
    chk("mis_word0", ram[0], 32'h8070_F0A5);
    chk("mis_word1", ram[1], 32'hABCD_FF44);

    // Reset during the write cycle of a byte store.
    issue(3'd6, 32'h4, 32'h77, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_abort(cyc);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_done",  32'(done),      32'd0);
    chk("abort_rdata", rdata,          32'h0);
    step(2);
    chk("abort_word",  ram[1],         32'hABCD_FF44);

    // Continuous req_valid with alternating ops.
    d0 = done_seen;
    issue(3'd5, 32'h1001_0010, 32'h0000_CAFE, 1);
    issue(3'd0, 32'h1001_0010, 32'h0, 1);
    issue(3'd6, 32'h1001_0011, 32'h5A, 1);
    issue(3'd5, 32'h0000_2008, 32'h1234, 1);
    issue(3'd0, 32'h1001_0010, 32'h0, 1);
    issue(3'd2, 32'h1001_0011, 32'h0, 0);
    step(4);
    chk("hold_done_count", 32'(done_seen - d0), 32'd6);
    chk("hold_rdata",      rdata,               32'h0000_005A);
    chk("hold_word4",      ram[4],              32'h0000_5AFE);
    chk("wrap_word2",      ram[2],              32'h0000_1234);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle CPU's execute stage and a word-wide synchronous data RAM.
- Accepts one load or store request at a time and maps MARS-style data addresses (base 32'h1001_0000) onto a RAM word index.
- Performs byte/halfword extraction with sign or zero extension for loads, and read-modify-write for SB/SH.
- Stalls the CPU through a ready/done handshake.

Parameters:
- DATA_BASE, 32'h1001_0000, data segment base subtracted from addresses at or above it.
- DEPTH_W, 11, RAM word-index width (2048 words).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present; requester holds op/addr/wdata until accepted
- req_ready  out  1  high only in IDLE; acceptance = req_valid & req_ready at a clk edge
- op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
- addr  in  32  byte address
- wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
- rdata  out  32  load result, registered, held until next load completes
- done  out  1  one-cycle pulse at completion of every accepted request
- addr_err  out  1  one-cycle pulse with done for a misaligned request
- busy  out  1  state != IDLE
- ram_addr  out  DEPTH_W  word index
- ram_rena  out  1  RAM read enable; RAM returns ram_rdata on the next cycle
- ram_wena  out  1  RAM write enable; write occurs at the clk edge
- ram_wdata  out  32  word to write
- ram_rdata  in  32  registered RAM read data

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; rdata=0; done=0; addr_err=0; latched op/addr/wdata=0.
  - req_ready=1 from the following cycle.
- Reset mid-operation: aborts at that edge, returns to IDLE with no done pulse. ram_wena is gated by ~rst, so a cycle with rst high never writes.
- Address map:
  - off = addr - DATA_BASE if addr >= DATA_BASE, else addr.
  - ram_addr = off[DEPTH_W+1:2]; upper bits ignored (wrap).
  - k = addr[1:0].
- Lanes are little-endian:
  - byte k = word[8k+7:8k].
  - halfword at k=0 is [15:0]; at k=2 it is [31:16].
- Alignment: LW/SW require k=00; LH/LHU/SH require k[0]=0; byte ops are always aligned.
- Request/response latches op, addr and wdata at acceptance.
- States: IDLE, RD, CAP, WR.
- IDLE:
  - On acceptance with a misaligned request: done=1 and addr_err=1 at the next edge; stay IDLE; no RAM access; rdata unchanged.
  - On acceptance of SW: go to WR.
  - On acceptance of any other op: go to RD.
- RD: ram_rena=1, ram_addr valid. Next state CAP.
- CAP: ram_rdata valid.
  - Load: at the edge, rdata = extracted value; LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word. done=1. Next state IDLE.
  - SB/SH: merge wdata bytes into the read word, kept in a register. Next state WR.
- WR:
  - ram_wena=1 and ram_wdata = wdata (SW) or the merged word (SB/SH).
  - At the edge done=1. Next state IDLE.
- Latency (done high in cycle N after the acceptance edge):
  - LW/LB/LBU/LH/LHU: N=2.
  - SW: N=1.
  - SB/SH: N=3.
  - Misaligned: N=1.
- Back-to-back: a new request may be accepted in the cycle done is high, since state is already IDLE. Max throughput is one SW every 2 cycles.
- req_valid while busy: ignored; no queueing.
- ram_rena and ram_wena are never high in the same cycle. Both are 0 in IDLE.

Test Plan:
- Reset, then SW addr=32'h1001_0008, wdata=123456 -> ram_wena for one cycle with ram_addr=2, ram_wdata=123456; done at N=1. Then LW same addr -> rdata=123456 at N=2, addr_err=0.
- Preload word 0 = 32'h8070_F0A5.
  - LB addr 0 -> rdata=32'hFFFF_FFA5.
  - LBU addr 3 -> 32'h0000_0080.
  - LH addr 2 -> 32'hFFFF_8070.
  - LHU addr 0 -> 32'h0000_F0A5.
- Word 1 = 32'h1122_3344.
  - SB addr 5, wdata=32'hFF -> word becomes 32'h1122_FF44; done at N=3.
  - Then SH addr 6, wdata=32'hABCD -> 32'hABCD_FF44.
- Misaligned LW addr 2, LH addr 1, SH addr 3 -> each gives done and addr_err at N=1; no ram_rena/ram_wena; RAM contents and rdata unchanged.
- SB accepted, rst asserted during the WR cycle -> no write (word unchanged), no done, state IDLE, req_ready=1 the next cycle.
- req_valid held continuously with SW, LW, SB alternating -> each accepted only in IDLE; req_valid while busy is never accepted; done count equals request count.
